stage_sequencer: RTL and testbench
==================================

// Module: stage_sequencer
// PURPOSE
//  Multicycle control FSM for the AVR-subset CPU. Steps each instruction through IF->ID->EX->MEM->WB.
//  Its pipeline_stage and cycle_count outputs drive signal_generation_unit, which is purely combinational.
//  Instructions with two stack accesses (RCALL, RET) get a second MEM cycle.
//  Also flags instruction retirement and keeps a retired-instruction counter for the bench and debug.
// PARAMETERS
//  CNT_W  16  width of retired_count; the counter wraps modulo 2^CNT_W
// PORTS
//  clk             in   1              system clock; all state updates on rising edge
//  reset           in   1              asynchronous, active-low reset
//  stall           in   1              1 = freeze the sequencer: stage, cycle_count, latch and counter all hold
//  opcode_type     in   `OPCODE_COUNT  encoded TYPE_* from the decoder; valid during STAGE_ID
//  pipeline_stage  out  `STAGE_COUNT   current stage, one of the STAGE_IF/ID/EX/MEM/WB encodings
//  cycle_count     out  1              0 = first cycle of a stage; 1 = second MEM cycle
//  instr_retired   out  1              1-cycle pulse: pipeline_stage==STAGE_WB && !stall (combinational)
//  retired_count   out  CNT_W          number of instructions retired since reset
// BEHAVIOUR
//  Reset (reset==0, asynchronous, no clock needed)
//   - pipeline_stage=STAGE_IF, cycle_count=0, two_mem_q=0, retired_count=0.
//   - instr_retired=0, because the stage is IF.
//   - Reset asserted mid-instruction abandons it. The next instruction starts at IF with cycle_count=0.
//  Internal latch two_mem_q
//   - Loaded on the ID->EX edge (stage==ID, !stall) with (opcode_type==`TYPE_RCALL || opcode_type==`TYPE_RET).
//   - Any opcode_type change after ID does not affect the current instruction.
//   - opcode_type is ignored in every stage except ID.
//  Transitions (only on a rising edge with stall==0)
//   - IF->ID, ID->EX, EX->MEM; cycle_count stays 0.
//   - MEM, cycle_count==0, two_mem_q==1: stay in MEM, cycle_count<=1.
//   - MEM, cycle_count==0, two_mem_q==0: go to WB, cycle_count stays 0.
//   - MEM, cycle_count==1: go to WB, cycle_count<=0.
//   - WB->IF; retired_count<=retired_count+1 (wraps, e.g. 2^CNT_W-1 -> 0).
//   - Any unused stage encoding: go to IF, cycle_count<=0. The counter does not increment.
//  Invariants
//   - cycle_count==1 only while pipeline_stage==STAGE_MEM.
//   - Latency: 5 cycles per normal instruction, 6 per RCALL/RET, plus any stalled cycles.
//  Stall
//   - stall==1 holds every register, including across the two MEM cycles.
//   - instr_retired is 0 while stall==1, so a stall in WB never double-counts.
//   - Stall and reset together: reset wins.
//  Outputs pipeline_stage, cycle_count and retired_count come directly from flops (glitch-free).
// TESTING
//  T1 Release reset with stall=0, opcode_type=TYPE_ADD:
//     stages IF,ID,EX,MEM,WB,IF on 5 consecutive edges; cycle_count always 0; instr_retired high once.
//  T2 opcode_type=TYPE_RET in ID: IF,ID,EX,MEM(cc0),MEM(cc1),WB,IF.
//     6 cycles; retired_count +1. Repeat with TYPE_RCALL: same sequence.
//  T3 TYPE_RET in ID, then opcode_type=TYPE_ADD from EX onward: second MEM cycle still occurs.
//     Reverse case: ADD in ID, RET afterwards -> only one MEM cycle.
//  T4 stall=1 for 3 cycles during MEM cc1 of RET:
//     stage and cycle_count hold for 3 cycles; WB follows one edge after stall drops; count +1 exactly once.
//  T5 reset pulsed low mid-cycle (asynchronous) during MEM cc1:
//     outputs go to IF/0/0 immediately; the next instruction takes a normal 5-cycle sequence.
//  T6 CNT_W=4, retire 17 ADD instructions: retired_count reads 15 after #15, 0 after #16, 1 after #17.

Source files
------------

// File: rtl/stage_sequencer_if.sv
// Control bundle between the stage sequencer and its consumers: stall/opcode in, stage/retire status out.
interface stage_sequencer_if #(
    parameter int unsigned CNT_W = 16
);
    logic             stall;
    logic [3:0]       opcode_type;
    logic [2:0]       pipeline_stage;
    logic             cycle_count;
    logic             instr_retired;
    logic [CNT_W-1:0] retired_count;

    // slave: the sequencer itself; master: the decoder/control side around it
    modport slave (
        input  stall,
        input  opcode_type,
        output pipeline_stage,
        output cycle_count,
        output instr_retired,
        output retired_count
    );

    modport master (
        output stall,
        output opcode_type,
        input  pipeline_stage,
        input  cycle_count,
        input  instr_retired,
        input  retired_count
    );
endinterface

// File: rtl/stage_sequencer.sv
// Multicycle IF->ID->EX->MEM->WB sequencer for the AVR-subset CPU.
// RCALL/RET take a second MEM cycle; retirements are pulsed and counted.
module stage_sequencer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    stage_sequencer_if.slave  bus
);
    localparam logic [2:0] STAGE_IF  = 3'd0;
    localparam logic [2:0] STAGE_ID  = 3'd1;
    localparam logic [2:0] STAGE_EX  = 3'd2;
    localparam logic [2:0] STAGE_MEM = 3'd3;
    localparam logic [2:0] STAGE_WB  = 3'd4;

    localparam logic [3:0] TYPE_RCALL = 4'd9;
    localparam logic [3:0] TYPE_RET   = 4'd10;

    logic [2:0]       stage_q, stage_d;
    logic             cc_q, cc_d;
    logic             two_mem_q, two_mem_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        stage_d   = stage_q;
        cc_d      = cc_q;
        two_mem_d = two_mem_q;
        cnt_d     = cnt_q;
        if (!bus.stall) begin
            case (stage_q)
                STAGE_IF: stage_d = STAGE_ID;
                STAGE_ID: begin
                    stage_d   = STAGE_EX;
                    two_mem_d = (bus.opcode_type == TYPE_RCALL) || (bus.opcode_type == TYPE_RET);
                end
                STAGE_EX: stage_d = STAGE_MEM;
                STAGE_MEM: begin
                    // second stack access: linger one extra cycle in MEM
                    if (!cc_q && two_mem_q) begin
                        cc_d = 1'b1;
                    end else begin
                        stage_d = STAGE_WB;
                        cc_d    = 1'b0;
                    end
                end
                STAGE_WB: begin
                    stage_d = STAGE_IF;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
                default: begin
                    stage_d = STAGE_IF;
                    cc_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stage_q   <= STAGE_IF;
            cc_q      <= 1'b0;
            two_mem_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            stage_q   <= stage_d;
            cc_q      <= cc_d;
            two_mem_q <= two_mem_d;
            cnt_q     <= cnt_d;
        end
    end

    assign bus.pipeline_stage = stage_q;
    assign bus.cycle_count    = cc_q;
    assign bus.instr_retired  = (stage_q == STAGE_WB) && !bus.stall;
    assign bus.retired_count  = cnt_q;
endmodule

// File: tb/tb_stage_sequencer.sv
// Scoreboard bench: two sequencers (16-bit and 4-bit counters) share stimulus; a monitor checks per-cycle expectations.
module tb_stage_sequencer;
    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;
    localparam logic [3:0] T_ADD   = 4'd0;
    localparam logic [3:0] T_RCALL = 4'd9;
    localparam logic [3:0] T_RET   = 4'd10;

    typedef struct {
        logic [2:0]  stg;
        logic        cc;
        logic        ret;
        int unsigned cnt;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    logic stall;
    logic [3:0] opcode;
    int checks = 0;
    int errors = 0;
    int unsigned cnt = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    stage_sequencer_if #(.CNT_W(16)) bus ();
    stage_sequencer_if #(.CNT_W(4))  bus4 ();
    assign bus.stall        = stall;
    assign bus.opcode_type  = opcode;
    assign bus4.stall       = stall;
    assign bus4.opcode_type = opcode;

    stage_sequencer #(.CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus));
    stage_sequencer #(.CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("stage", int'(bus.pipeline_stage), int'(e.stg));
                chk("cycle_count", int'(bus.cycle_count), int'(e.cc));
                chk("instr_retired", int'(bus.instr_retired), int'(e.ret));
                chk("retired_count", int'(bus.retired_count), int'(e.cnt % 65536));
                chk("stage_w4", int'(bus4.pipeline_stage), int'(e.stg));
                chk("retired_count_w4", int'(bus4.retired_count), int'(e.cnt % 16));
            end
        end
    end

    // One instruction: op is presented in ID, fill elsewhere (or random when rnd).
    // Forced stall of st_len cycles at step st_step; asynchronous reset at step rst_step.
    task automatic run_instr(input logic [3:0] op, input logic [3:0] fill, input bit rnd,
                             input int st_step, input int st_len, input int rst_step);
        bit   two;
        int   n;
        int   forced;
        exp_t e;
        two = (op == T_RCALL) || (op == T_RET);
        n   = two ? 6 : 5;
        for (int i = 0; i < n; i++) begin
            forced = (i == st_step) ? st_len : 0;
            do begin
                @(negedge clk);
                if (forced > 0) begin
                    stall = 1'b1;
                    forced--;
                end else if (rnd && i != rst_step) begin
                    stall = ($urandom_range(0, 3) == 0);
                end else begin
                    stall = 1'b0;
                end
                opcode = (i == 1) ? op : (rnd ? 4'($urandom_range(0, 15)) : fill);
                e.stg = (i < 4) ? 3'(i) : ((i == n - 1) ? S_WB : S_MEM);
                e.cc  = two && (i == 4);
                e.ret = (e.stg == S_WB) && !stall;
                e.cnt = cnt;
                q.push_back(e);
                if (e.ret) cnt++;
                if (i == rst_step) begin
                    #3 reset = 1'b0;
                    #1;
                    chk("async_reset_stage", int'(bus.pipeline_stage), int'(S_IF));
                    chk("async_reset_cc", int'(bus.cycle_count), 0);
                    chk("async_reset_count", int'(bus.retired_count), 0);
                    chk("async_reset_retired", int'(bus.instr_retired), 0);
                    cnt = 0;
                    @(posedge clk);
                    #1 reset = 1'b1;
                    return;
                end
            end while (stall);
        end
    endtask

    initial begin : stimulus
        logic [3:0] op;
        reset  = 1'b0;
        stall  = 1'b0;
        opcode = T_ADD;
        repeat (2) @(negedge clk);
        chk("reset_stage", int'(bus.pipeline_stage), int'(S_IF));
        chk("reset_cc", int'(bus.cycle_count), 0);
        chk("reset_retired", int'(bus.instr_retired), 0);
        chk("reset_count", int'(bus.retired_count), 0);
        chk("reset_count_w4", int'(bus4.retired_count), 0);
        @(posedge clk);
        #1 reset = 1'b1;

        run_instr(T_ADD,   T_ADD, 1'b0, -1, 0, -1);
        run_instr(T_RET,   T_RET, 1'b0, -1, 0, -1);
        run_instr(T_RCALL, T_RCALL, 1'b0, -1, 0, -1);
        run_instr(T_RET,   T_ADD, 1'b0, -1, 0, -1);
        run_instr(T_ADD,   T_RET, 1'b0, -1, 0, -1);
        run_instr(T_RET,   T_ADD, 1'b0, 4, 3, -1);
        run_instr(T_RET,   T_ADD, 1'b0, 5, 2, -1);
        run_instr(T_RET,   T_ADD, 1'b0, -1, 0, 4);
        run_instr(T_ADD,   T_ADD, 1'b0, -1, 0, -1);
        for (int k = 0; k < 20; k++) run_instr(T_ADD, T_ADD, 1'b0, -1, 0, -1);
        for (int k = 0; k < 80; k++) begin
            case ($urandom_range(0, 3))
                0:       op = T_RET;
                1:       op = T_RCALL;
                default: op = 4'($urandom_range(0, 15));
            endcase
            run_instr(op, T_ADD, 1'b1, -1, 0, -1);
        end
        repeat (2) @(negedge clk);
        chk("scoreboard_drained", q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        errors++;
        $display("FAIL watchdog actual=timeout expected=completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
